// File: rtl/rvee_bus_pkg.sv
// ============================================================================
// Module      : rvee_bus_pkg
// Description : Shared types for the fetch/data bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rvee_bus_pkg;

  typedef enum logic {
    RVEE_OWN_F = 1'b0,
    RVEE_OWN_D = 1'b1
  } rvee_owner_e;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_HOLD_F = 2'd1,
    ARB_HOLD_D = 2'd2
  } rvee_arb_state_e;

  typedef struct packed {
    rvee_owner_e owner;
    logic        kill;
  } rvee_idq_entry_t;

  localparam logic [1:0] c_size_byte = 2'd0;
  localparam logic [1:0] c_size_half = 2'd1;
  localparam logic [1:0] c_size_word = 2'd2;

endpackage

`default_nettype wire

// File: rtl/rvee_bus_idq.sv
// ============================================================================
// Module      : rvee_bus_idq
// Description : In-order queue of outstanding bus requests {owner, kill}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rvee_bus_idq
  import rvee_bus_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  rvee_idq_entry_t push_entry,
  input  logic            pop,
  input  logic            kill_f,
  output rvee_idq_entry_t head,
  output logic            full,
  output logic            empty
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PW-1:0] c_last  = PW'(MAX_OUTSTANDING - 1);
  localparam logic [CW-1:0] c_depth = CW'(MAX_OUTSTANDING);

  rvee_idq_entry_t r_mem [MAX_OUTSTANDING];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign full   = (r_count == c_depth);
  assign empty  = (r_count == '0);
  assign head   = r_mem[r_rptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      // The slot written this cycle holds a request accepted after the flush
      // was raised, so it takes the new entry rather than the kill mark.
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (w_push && (r_wptr == PW'(i))) begin
          r_mem[i] <= push_entry;
        end else if (kill_f && (r_mem[i].owner == RVEE_OWN_F)) begin
          r_mem[i].kill <= 1'b1;
        end
      end
      if (w_push) begin
        r_wptr <= (r_wptr == c_last) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == c_last) ? '0 : r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/rvee_bus_arb.sv
// ============================================================================
// Module      : rvee_bus_arb
// Description : Fetch/data arbiter for a single in-order memory bus port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rvee_bus_arb
  import rvee_bus_pkg::*;
#(
  parameter int AWIDTH          = 32,
  parameter int DWIDTH          = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_MAX      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req_valid,
  output logic              f_req_ready,
  input  logic [AWIDTH-1:0] f_req_addr,
  input  logic              f_flush,
  output logic              f_rsp_valid,
  output logic [DWIDTH-1:0] f_rsp_data,
  input  logic              m_req_valid,
  output logic              m_req_ready,
  input  logic [AWIDTH-1:0] m_req_addr,
  input  logic              m_req_we,
  input  logic [DWIDTH-1:0] m_req_wdata,
  input  logic [1:0]        m_req_size,
  output logic              m_rsp_valid,
  output logic [DWIDTH-1:0] m_rsp_data,
  output logic              b_req_valid,
  input  logic              b_req_ready,
  output logic [AWIDTH-1:0] b_req_addr,
  output logic              b_req_we,
  output logic [DWIDTH-1:0] b_req_wdata,
  output logic [1:0]        b_req_size,
  input  logic              b_rsp_valid,
  input  logic [DWIDTH-1:0] b_rsp_data,
  output logic              err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] c_starve_max = SW'(STARVE_MAX);

  rvee_arb_state_e   r_state;
  logic [SW-1:0]     r_starve;
  logic              r_f_rsp_valid;
  logic [DWIDTH-1:0] r_f_rsp_data;
  logic              r_m_rsp_valid;
  logic [DWIDTH-1:0] r_m_rsp_data;
  logic              r_err;

  logic              w_gnt_valid;
  rvee_owner_e       w_gnt_owner;
  logic              w_f_granted;
  logic              w_xfer;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_head_kill;
  rvee_idq_entry_t   w_head;
  rvee_idq_entry_t   w_push_entry;

  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_owner = RVEE_OWN_D;
    case (r_state)
      ARB_HOLD_F: begin
        w_gnt_valid = f_req_valid;
        w_gnt_owner = RVEE_OWN_F;
      end
      ARB_HOLD_D: begin
        w_gnt_valid = m_req_valid;
        w_gnt_owner = RVEE_OWN_D;
      end
      default: begin
        if (f_req_valid && ((r_starve == c_starve_max) || !m_req_valid)) begin
          w_gnt_valid = 1'b1;
          w_gnt_owner = RVEE_OWN_F;
        end else if (m_req_valid) begin
          w_gnt_valid = 1'b1;
          w_gnt_owner = RVEE_OWN_D;
        end
      end
    endcase
  end

  // Request-side outputs are combinational, so they are gated with rst to
  // read zero throughout reset without waiting for a clock.
  assign b_req_valid = !rst && w_gnt_valid && !w_full;
  assign w_xfer      = b_req_valid && b_req_ready;
  assign f_req_ready = w_xfer && (w_gnt_owner == RVEE_OWN_F);
  assign m_req_ready = w_xfer && (w_gnt_owner == RVEE_OWN_D);
  assign w_f_granted = w_gnt_valid && (w_gnt_owner == RVEE_OWN_F);

  always_comb begin
    b_req_addr  = '0;
    b_req_we    = 1'b0;
    b_req_wdata = '0;
    b_req_size  = '0;
    if (!rst) begin
      if (w_gnt_owner == RVEE_OWN_F) begin
        b_req_addr = f_req_addr;
        b_req_size = c_size_word;
      end else begin
        b_req_addr  = m_req_addr;
        b_req_we    = m_req_we;
        b_req_wdata = m_req_wdata;
        b_req_size  = m_req_size;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ARB_IDLE;
      r_starve <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (b_req_valid && !b_req_ready) begin
            r_state <= (w_gnt_owner == RVEE_OWN_F) ? ARB_HOLD_F : ARB_HOLD_D;
          end
        end
        ARB_HOLD_F, ARB_HOLD_D: begin
          if (w_xfer) begin
            r_state <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
      if (f_req_ready) begin
        r_starve <= '0;
      end else if (f_req_valid && !w_f_granted && (r_starve != c_starve_max)) begin
        r_starve <= r_starve + 1'b1;
      end
    end
  end

  assign w_push_entry = '{owner: w_gnt_owner, kill: 1'b0};
  assign w_pop        = b_rsp_valid && !w_empty;
  // A flush in the same cycle as the head's response still kills it.
  assign w_head_kill  = w_head.kill || (f_flush && (w_head.owner == RVEE_OWN_F));

  rvee_bus_idq #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_idq (
    .clk       (clk),
    .rst       (rst),
    .push      (w_xfer),
    .push_entry(w_push_entry),
    .pop       (w_pop),
    .kill_f    (f_flush),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_f_rsp_valid <= 1'b0;
      r_f_rsp_data  <= '0;
      r_m_rsp_valid <= 1'b0;
      r_m_rsp_data  <= '0;
      r_err         <= 1'b0;
    end else begin
      r_f_rsp_valid <= w_pop && (w_head.owner == RVEE_OWN_F) && !w_head_kill;
      r_m_rsp_valid <= w_pop && (w_head.owner == RVEE_OWN_D);
      if (w_pop && (w_head.owner == RVEE_OWN_F) && !w_head_kill) begin
        r_f_rsp_data <= b_rsp_data;
      end
      if (w_pop && (w_head.owner == RVEE_OWN_D)) begin
        r_m_rsp_data <= b_rsp_data;
      end
      if (b_rsp_valid && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  assign f_rsp_valid = r_f_rsp_valid;
  assign f_rsp_data  = r_f_rsp_data;
  assign m_rsp_valid = r_m_rsp_valid;
  assign m_rsp_data  = r_m_rsp_data;
  assign err         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_rvee_bus_arb.sv
// ============================================================================
// Module      : tb_rvee_bus_arb
// Description : Directed self-checking bench for rvee_bus_arb.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rvee_bus_arb;

  logic        clk;
  logic        rst;
  logic        f_req_valid;
  logic        f_req_ready;
  logic [31:0] f_req_addr;
  logic        f_flush;
  logic        f_rsp_valid;
  logic [31:0] f_rsp_data;
  logic        m_req_valid;
  logic        m_req_ready;
  logic [31:0] m_req_addr;
  logic        m_req_we;
  logic [31:0] m_req_wdata;
  logic [1:0]  m_req_size;
  logic        m_rsp_valid;
  logic [31:0] m_rsp_data;
  logic        b_req_valid;
  logic        b_req_ready;
  logic [31:0] b_req_addr;
  logic        b_req_we;
  logic [31:0] b_req_wdata;
  logic [1:0]  b_req_size;
  logic        b_rsp_valid;
  logic [31:0] b_rsp_data;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  rvee_bus_arb #(
    .AWIDTH(32), .DWIDTH(32), .MAX_OUTSTANDING(2), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst(rst),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
    .f_flush(f_flush), .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_we(m_req_we), .m_req_wdata(m_req_wdata), .m_req_size(m_req_size),
    .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_addr(b_req_addr),
    .b_req_we(b_req_we), .b_req_wdata(b_req_wdata), .b_req_size(b_req_size),
    .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        f_v;
    logic        m_v;
    logic        rdy;
    logic        rsp_v;
    logic [31:0] rsp_d;
    logic        e_bv;
    logic        e_fr;
    logic        e_mr;
    logic        e_fv;
    logic        e_mv;
    logic [31:0] e_addr;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    f_req_valid = 1'b0; f_req_addr = '0; f_flush = 1'b0;
    m_req_valid = 1'b0; m_req_addr = '0; m_req_we = 1'b0;
    m_req_wdata = '0; m_req_size = 2'd0;
    b_req_ready = 1'b0; b_rsp_valid = 1'b0; b_rsp_data = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " outputs"},
        {f_req_ready, f_rsp_valid, m_req_ready, m_rsp_valid, b_req_valid, b_req_we, b_req_size, err},
        64'd0);
    chk({tag, " data"}, {b_req_addr, b_req_wdata} | {f_rsp_data, m_rsp_data}, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    #1;
    check_all_zero("reset");

    // Starvation: data wins 4 cycles, fetch the 5th, then data again.
    // Bus answers every request on the following cycle with 0xA0+row.
    vecs[0] = '{1,1,1,0,32'h00, 1,0,1,0,0, 32'h2000, 32'h0};
    vecs[1] = '{1,1,1,1,32'hA1, 1,0,1,0,0, 32'h2000, 32'h0};
    vecs[2] = '{1,1,1,1,32'hA2, 1,0,1,0,1, 32'h2000, 32'hA1};
    vecs[3] = '{1,1,1,1,32'hA3, 1,0,1,0,1, 32'h2000, 32'hA2};
    vecs[4] = '{1,1,1,1,32'hA4, 1,1,0,0,1, 32'h0100, 32'hA3};
    vecs[5] = '{1,1,1,1,32'hA5, 1,0,1,0,1, 32'h2000, 32'hA4};
    vecs[6] = '{0,0,1,1,32'hA6, 0,0,0,1,0, 32'h0,    32'hA5};
    vecs[7] = '{0,0,1,0,32'h00, 0,0,0,0,1, 32'h0,    32'hA6};

    apply_reset();
    f_req_addr = 32'h100;
    m_req_addr = 32'h2000;
    for (int i = 0; i < 8; i++) begin
      tick();
      f_req_valid = vecs[i].f_v;
      m_req_valid = vecs[i].m_v;
      b_req_ready = vecs[i].rdy;
      b_rsp_valid = vecs[i].rsp_v;
      b_rsp_data  = vecs[i].rsp_d;
      @(negedge clk);
      chk($sformatf("starve row%0d ctl", i),
          {b_req_valid, f_req_ready, m_req_ready, f_rsp_valid, m_rsp_valid, err},
          {vecs[i].e_bv, vecs[i].e_fr, vecs[i].e_mr, vecs[i].e_fv, vecs[i].e_mv, 1'b0});
      if (vecs[i].e_bv) chk($sformatf("starve row%0d addr", i), b_req_addr, vecs[i].e_addr);
      if (vecs[i].e_fv) chk($sformatf("starve row%0d fdata", i), f_rsp_data, vecs[i].e_rdata);
      if (vecs[i].e_mv) chk($sformatf("starve row%0d mdata", i), m_rsp_data, vecs[i].e_rdata);
    end

    // Fetch offered while bus stalls; data arriving later must not steal it.
    apply_reset();
    tick();
    f_req_valid = 1'b1; f_req_addr = 32'h300; m_req_size = 2'd1;
    @(negedge clk);
    chk("hold c0 valid/ready", {b_req_valid, f_req_ready, m_req_ready}, 3'b100);
    chk("hold c0 size", b_req_size, 2'd2);
    for (int c = 1; c < 3; c++) begin
      tick();
      m_req_valid = 1'b1; m_req_addr = 32'h2000;
      @(negedge clk);
      chk($sformatf("hold c%0d ready", c), {b_req_valid, f_req_ready, m_req_ready}, 3'b100);
      chk($sformatf("hold c%0d addr", c), b_req_addr, 32'h300);
    end
    tick();
    b_req_ready = 1'b1;
    @(negedge clk);
    chk("hold handshake", {f_req_ready, m_req_ready}, 2'b10);
    chk("hold fetch size", b_req_size, 2'd2);
    tick();
    f_req_valid = 1'b0;
    @(negedge clk);
    chk("hold then data", {m_req_ready, b_req_addr}, {1'b1, 32'h2000});

    // Outstanding limit, and a response only unblocks issue a cycle later.
    apply_reset();
    tick();
    m_req_valid = 1'b1; m_req_addr = 32'h40; b_req_ready = 1'b1;
    @(negedge clk);
    chk("full c0 accept", m_req_ready, 1'b1);
    tick();
    @(negedge clk);
    chk("full c1 accept", m_req_ready, 1'b1);
    tick();
    b_rsp_valid = 1'b1; b_rsp_data = 32'h55;
    @(negedge clk);
    chk("full c2 blocked", {b_req_valid, m_req_ready}, 2'b00);
    tick();
    b_rsp_valid = 1'b0;
    @(negedge clk);
    chk("full c3 reissue", {b_req_valid, m_req_ready, m_rsp_valid}, 3'b111);
    chk("full c3 rdata", m_rsp_data, 32'h55);
    tick();
    m_req_valid = 1'b0;
    m_req_valid = 1'b1;
    @(negedge clk);
    chk("full c4 blocked", b_req_valid, 1'b0);

    // Flush kills the older fetch but not one accepted in the flush cycle.
    apply_reset();
    tick();
    f_req_valid = 1'b1; f_req_addr = 32'h100; b_req_ready = 1'b1;
    @(negedge clk);
    chk("flush c0 accept", f_req_ready, 1'b1);
    tick();
    f_req_addr = 32'h200; f_flush = 1'b1;
    @(negedge clk);
    chk("flush c1 accept in flush", {f_req_ready, b_req_addr}, {1'b1, 32'h200});
    tick();
    f_flush = 1'b0; f_req_valid = 1'b0;
    m_req_valid = 1'b1; m_req_addr = 32'h2000;
    b_rsp_valid = 1'b1; b_rsp_data = 32'h11;
    @(negedge clk);
    chk("flush c2 full", b_req_valid, 1'b0);
    tick();
    b_rsp_data = 32'h22;
    @(negedge clk);
    chk("flush c3 killed dropped", {f_rsp_valid, m_rsp_valid, m_req_ready}, 3'b001);
    tick();
    m_req_valid = 1'b0; b_rsp_data = 32'h33;
    @(negedge clk);
    chk("flush c4 fetch rsp", {f_rsp_valid, m_rsp_valid, f_rsp_data}, {2'b10, 32'h22});
    tick();
    b_rsp_valid = 1'b0;
    @(negedge clk);
    chk("flush c5 data rsp", {f_rsp_valid, m_rsp_valid, m_rsp_data}, {2'b01, 32'h33});

    // Byte store passes through and its ack returns on the data side.
    apply_reset();
    tick();
    m_req_valid = 1'b1; m_req_we = 1'b1; m_req_size = 2'd0;
    m_req_wdata = 32'hAB; m_req_addr = 32'h44; b_req_ready = 1'b1;
    @(negedge clk);
    chk("store fields", {b_req_valid, m_req_ready, b_req_we, b_req_size, b_req_wdata, b_req_addr},
        {3'b111, 2'd0, 32'hAB, 32'h44});
    tick();
    m_req_valid = 1'b0; m_req_we = 1'b0;
    b_rsp_valid = 1'b1; b_rsp_data = 32'h0;
    @(negedge clk);
    chk("store ack pending", m_rsp_valid, 1'b0);
    tick();
    b_rsp_valid = 1'b0;
    @(negedge clk);
    chk("store ack", {m_rsp_valid, f_rsp_valid}, 2'b10);

    // Spurious response sets sticky err; async reset clears everything.
    apply_reset();
    tick();
    b_rsp_valid = 1'b1; b_rsp_data = 32'h77;
    @(negedge clk);
    chk("err before edge", err, 1'b0);
    tick();
    b_rsp_valid = 1'b0;
    f_req_valid = 1'b1; f_req_addr = 32'h500;
    m_req_valid = 1'b1; m_req_addr = 32'h600;
    @(negedge clk);
    chk("err set", {err, f_rsp_valid, m_rsp_valid, b_req_valid}, 4'b1001);
    tick();
    @(negedge clk);
    chk("err sticky", err, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("after reset", {err, b_req_valid, b_req_addr}, {2'b01, 32'h600});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rvee_bus_arb.md
Name: rvee_bus_arb

Overview:
Shares one memory bus port between instruction fetch (driven by rvee_pcgen) and the data port (driven by load/store results from rvee_exec via rvee_mem). Arbitrates requests, returns responses in order to the owner, and discards fetch responses killed by a pipeline redirect (f_flush).

Parameters:
AWIDTH, 32, address width
DWIDTH, 32, data width
MAX_OUTSTANDING, 2, max accepted-but-unanswered bus requests (power of two, >=1)
STARVE_MAX, 4, consecutive cycles fetch may lose to data before fetch gets priority

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
f_req_valid  in  1  fetch request valid
f_req_ready  out  1  fetch request accepted
f_req_addr  in  AWIDTH  fetch address
f_flush  in  1  redirect; kill fetch entries outstanding at cycle start
f_rsp_valid  out  1  fetch response (always accepted)
f_rsp_data  out  DWIDTH  fetch instruction word
m_req_valid  in  1  data request valid
m_req_ready  out  1  data request accepted
m_req_addr  in  AWIDTH  data address
m_req_we  in  1  1=store
m_req_wdata  in  DWIDTH  store data
m_req_size  in  2  access size (0=byte, 1=half, 2=word)
m_rsp_valid  out  1  data response/store ack (always accepted)
m_rsp_data  out  DWIDTH  load data
b_req_valid  out  1  bus request valid
b_req_ready  in  1  bus accepts request
b_req_addr  out  AWIDTH  bus address
b_req_we  out  1  bus write
b_req_wdata  out  DWIDTH  bus write data
b_req_size  out  2  bus size (fetch forces 2)
b_rsp_valid  in  1  bus response, one per accepted request, in order
b_rsp_data  in  DWIDTH  bus response data
err  out  1  sticky: b_rsp_valid with nothing outstanding

Behaviour:
- Reset: all outputs 0; FIFO empty; starve counter 0; state IDLE; err 0. Reset mid-transaction drops everything; the bus is reset together with this block.
- Transfer occurs when b_req_valid && b_req_ready. At most one owner's ready high per cycle, equal to b_req_ready for that owner. Request fields are muxed combinationally from the granted owner. No path from b_rsp_* to b_req_*.
- FSM: IDLE, HOLD_F, HOLD_D. In IDLE, grant is chosen: data wins unless starve == STARVE_MAX, then fetch wins. If the grant is offered and not accepted, go to HOLD_<owner>. In HOLD, that owner stays granted until handshake, then return to IDLE. Requesters must hold valid and fields stable until ready.
- Full: FIFO count == MAX_OUTSTANDING forces b_req_valid=0. A response in the same cycle does not unblock issue until next cycle.
- Starve counter: +1 (saturating at STARVE_MAX) each cycle f_req_valid && fetch not granted. Cleared on fetch handshake.
- Outstanding FIFO entry {owner, kill} is pushed on bus handshake (kill=0). On f_flush, every fetch entry present at cycle start gets kill=1. A request accepted in the flush cycle is not killed.
- On b_rsp_valid, pop head. owner=D: m_rsp_valid=1. owner=F && !kill: f_rsp_valid=1. Killed: dropped. Data outputs follow b_rsp_data, registered: responses appear 1 cycle after b_rsp_valid. Simultaneous push and pop are both honoured.
- b_rsp_valid with empty FIFO: ignored, err<=1 until reset.

Decomposition:
- Package rvee_bus_pkg: owner enum (RVEE_OWN_F, RVEE_OWN_D), arb state enum, outstanding-entry struct {owner, kill}, size constants.
- Sub-module rvee_bus_idq: MAX_OUTSTANDING-deep entry FIFO with push, pop, count, full/empty and a broadcast kill-fetch input.

Test Plan:
- Both valid at the same time, b_req_ready=1, STARVE_MAX=4: data is granted for 4 cycles, fetch is granted on the 5th, then data again; starve goes back to 0.
- Fetch offered, b_req_ready=0 for 3 cycles while m_req_valid rises: grant stays on fetch (HOLD_F), and m_req_ready=0 until the fetch handshake.
- MAX_OUTSTANDING=2: two accepted requests with no response give b_req_valid=0. A response in cycle N gives a new issue possible in cycle N+1, not N.
- Issue F(0x100), D(load 0x2000), then f_flush, then F(0x200) in the flush cycle; respond to all 3: no f_rsp for 0x100, m_rsp_valid with data, f_rsp for 0x200.
- Store with m_req_size=0, wdata=0xAB: bus shows we=1, size=0, wdata=0xAB, and the ack gives m_rsp_valid=1. Fetch always shows size=2.
- b_rsp_valid while empty: err=1 and stays 1. Assert rst mid-run: all outputs 0 immediately, with no clock needed.
